// File: rtl/frame_fifo_write_pkg.sv
// Shared definitions for the frame write and frame read movers:
// state encodings, default burst/settle constants and a burst-length helper.
package frame_ddr3_pkg;

  localparam int          DEFAULT_BURST_SIZE     = 16;
  localparam int          DEFAULT_WAIT_CYCLES    = 200;
  localparam logic [23:0] DEFAULT_TIMEOUT_CYCLES = 24'd1_000_000;

  // Write-side burst mover states
  typedef enum logic [2:0] {
    S_IDLE            = 3'd0,
    S_ACK             = 3'd1,
    S_WAIT            = 3'd2,
    S_CHECK_FIFO      = 3'd3,
    S_WRITE_BURST     = 3'd4,
    S_WRITE_BURST_END = 3'd5,
    S_END             = 3'd6
  } wr_state_t;

  // Read-side burst mover states
  typedef enum logic [2:0] {
    RD_IDLE           = 3'd0,
    RD_ACK            = 3'd1,
    RD_WAIT           = 3'd2,
    RD_CHECK_FIFO     = 3'd3,
    RD_READ_BURST     = 3'd4,
    RD_READ_BURST_END = 3'd5,
    RD_END            = 3'd6
  } rd_state_t;

  // Length of the next burst: the nominal size, or whatever is left if smaller
  function automatic logic [31:0] clip_burst(input logic [31:0] remaining,
                                             input logic [31:0] burst_size);
    return (remaining < burst_size) ? remaining : burst_size;
  endfunction

endpackage

// File: rtl/frame_fifo_write_if.sv
// Burst-write handshake between the frame mover (master) and the memory
// controller (slave).
interface frame_fifo_write_if #(
  parameter int ADDR_BITS  = 23,
  parameter int BURST_BITS = 10
);
  logic                  wr_burst_req;
  logic [BURST_BITS-1:0] wr_burst_len;
  logic [ADDR_BITS-1:0]  wr_burst_addr;
  logic                  wr_burst_data_req;
  logic                  wr_burst_finish;

  modport master (
    output wr_burst_req, wr_burst_len, wr_burst_addr,
    input  wr_burst_data_req, wr_burst_finish
  );

  modport slave (
    input  wr_burst_req, wr_burst_len, wr_burst_addr,
    output wr_burst_data_req, wr_burst_finish
  );
endinterface

// File: rtl/frame_fifo_write_cdc_sync_bus.sv
// N-flop synchroniser for slow or quasi-static signals arriving from another
// clock domain. q is the output of the last stage.
module cdc_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             mem_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("cdc_sync_bus: STAGES must be at least 2");
  end

  logic [STAGES-1:0][WIDTH-1:0] sync_reg;

  // Shift the input through the flop chain; stage 0 samples the raw input
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/frame_fifo_write.sv
// Frame write mover: drains the video-input write FIFO into one of four frame
// buffers as memory bursts, shortening the last burst to the exact remainder.
// Optional watchdog: define FRAME_WR_TIMEOUT_EN to abort a frame whose FIFO
// stays too empty for TIMEOUT_CYCLES cycles while waiting for a burst.
module frame_fifo_write
  import frame_ddr3_pkg::*;
#(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = DEFAULT_BURST_SIZE,
  parameter int WAIT_CYCLES   = DEFAULT_WAIT_CYCLES
`ifdef FRAME_WR_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                 rst,
  input  logic                 mem_clk,
  frame_fifo_write_if.master   bus,
  output logic                 fifo_rden,
  input  logic                 write_req,
  output logic                 write_req_ack,
  output logic                 write_finish,
  input  logic [ADDR_BITS-1:0] write_addr_0,
  input  logic [ADDR_BITS-1:0] write_addr_1,
  input  logic [ADDR_BITS-1:0] write_addr_2,
  input  logic [ADDR_BITS-1:0] write_addr_3,
  input  logic [1:0]           write_addr_index,
  input  logic [ADDR_BITS-1:0] write_len,
  output logic                 fifo_aclr,
  input  logic [15:0]          rdusedw,
  output logic                 beat_overrun,
  output logic                 write_timeout
);

  if (BURST_SIZE < 1 || MEM_DATA_BITS < 1) begin : g_bad_params
    $error("frame_fifo_write: BURST_SIZE and MEM_DATA_BITS must be >= 1");
  end

  localparam int                   CMP_BITS     = (ADDR_BITS > 16) ? ADDR_BITS : 16;
  localparam logic [ADDR_BITS-1:0] WAIT_LIMIT   = ADDR_BITS'(WAIT_CYCLES);
  localparam logic [ADDR_BITS-1:0] ONE_A        = ADDR_BITS'(1);

  // Synchronised request and frame parameters
  logic                 req_d2;
  logic [ADDR_BITS-1:0] len_d1;
  logic [1:0]           index_d1;

  cdc_sync_bus #(.WIDTH(1), .STAGES(3)) u_req_sync (
    .mem_clk (mem_clk), .rst (rst), .d (write_req), .q (req_d2)
  );
  cdc_sync_bus #(.WIDTH(ADDR_BITS), .STAGES(2)) u_len_sync (
    .mem_clk (mem_clk), .rst (rst), .d (write_len), .q (len_d1)
  );
  cdc_sync_bus #(.WIDTH(2), .STAGES(2)) u_index_sync (
    .mem_clk (mem_clk), .rst (rst), .d (write_addr_index), .q (index_d1)
  );

  wr_state_t             state_reg, state_next;
  logic                  burst_req_reg, burst_req_next;
  logic [BURST_BITS-1:0] burst_len_reg, burst_len_next;
  logic [ADDR_BITS-1:0]  burst_addr_reg, burst_addr_next;
  logic                  ack_reg, ack_next;
  logic                  aclr_reg, aclr_next;
  logic                  finish_reg, finish_next;
  logic                  overrun_reg, overrun_next;
  logic [ADDR_BITS-1:0]  len_latch_reg, len_latch_next;
  logic [ADDR_BITS-1:0]  write_cnt_reg, write_cnt_next;
  logic [ADDR_BITS-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [ADDR_BITS-1:0]  beat_cnt_reg, beat_cnt_next;

`ifdef FRAME_WR_TIMEOUT_EN
  logic [23:0] wd_cnt_reg, wd_cnt_next;
  logic        timeout_reg, timeout_next;
`endif

  logic [ADDR_BITS-1:0] base_sel;
  logic [ADDR_BITS-1:0] remaining;
  logic [ADDR_BITS-1:0] blen;
  logic [ADDR_BITS-1:0] burst_len_ext;
  logic                 fifo_has_burst;
  logic                 beat_in_range;

  // Frame buffer base selected by the synchronised index
  always_comb begin
    case (index_d1)
      2'd0:    base_sel = write_addr_0;
      2'd1:    base_sel = write_addr_1;
      2'd2:    base_sel = write_addr_2;
      default: base_sel = write_addr_3;
    endcase
  end

  assign remaining      = len_latch_reg - write_cnt_reg;
  assign blen           = ADDR_BITS'(clip_burst(32'(remaining), 32'(BURST_SIZE)));
  assign fifo_has_burst = (CMP_BITS'(rdusedw) >= CMP_BITS'(blen));
  assign burst_len_ext  = ADDR_BITS'(burst_len_reg);
  assign beat_in_range  = (beat_cnt_reg < burst_len_ext);

  // Only beats within the granted length pull words out of the FIFO
  assign fifo_rden = (state_reg == S_WRITE_BURST) && bus.wr_burst_data_req && beat_in_range;

  // Next-state and next-output logic for the burst FSM
  always_comb begin
    state_next      = state_reg;
    burst_req_next  = burst_req_reg;
    burst_len_next  = burst_len_reg;
    burst_addr_next = burst_addr_reg;
    ack_next        = 1'b0;
    aclr_next       = 1'b0;
    len_latch_next  = len_latch_reg;
    write_cnt_next  = write_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    beat_cnt_next   = beat_cnt_reg;
`ifdef FRAME_WR_TIMEOUT_EN
    wd_cnt_next     = wd_cnt_reg;
    timeout_next    = 1'b0;
`endif

    case (state_reg)
      S_IDLE: begin
        if (req_d2) state_next = S_ACK;
      end
      S_ACK: begin
        if (req_d2) begin
          ack_next        = 1'b1;
          aclr_next       = 1'b1;
          burst_addr_next = base_sel;
          len_latch_next  = len_d1;
          write_cnt_next  = '0;
`ifdef FRAME_WR_TIMEOUT_EN
          wd_cnt_next     = '0;
`endif
        end else begin
          wait_cnt_next = '0;
          state_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg >= WAIT_LIMIT) state_next = S_CHECK_FIFO;
        else                            wait_cnt_next = wait_cnt_reg + ONE_A;
      end
      S_CHECK_FIFO: begin
        if (req_d2) begin
          state_next = S_ACK;
        end else if (remaining == '0) begin
          state_next = S_END;
        end else if (fifo_has_burst) begin
          burst_len_next = BURST_BITS'(blen);
          burst_req_next = 1'b1;
          beat_cnt_next  = '0;
`ifdef FRAME_WR_TIMEOUT_EN
          wd_cnt_next    = '0;
`endif
          state_next     = S_WRITE_BURST;
        end else begin
`ifdef FRAME_WR_TIMEOUT_EN
          if (wd_cnt_reg >= TIMEOUT_CYCLES - 24'd1) begin
            timeout_next = 1'b1;
            state_next   = S_END;
          end else begin
            wd_cnt_next = wd_cnt_reg + 24'd1;
          end
`endif
        end
      end
      S_WRITE_BURST: begin
        if (bus.wr_burst_data_req) burst_req_next = 1'b0;
        if (fifo_rden)             beat_cnt_next  = beat_cnt_reg + ONE_A;
        if (bus.wr_burst_finish) begin
          burst_req_next  = 1'b0;
          write_cnt_next  = write_cnt_reg + burst_len_ext;
          burst_addr_next = burst_addr_reg + burst_len_ext;
          state_next      = S_WRITE_BURST_END;
        end
      end
      S_WRITE_BURST_END: begin
        if (req_d2)                              state_next = S_ACK;
        else if (write_cnt_reg < len_latch_reg) state_next = S_CHECK_FIFO;
        else                                     state_next = S_END;
      end
      S_END: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    finish_next  = (state_next == S_END);
    overrun_next = (state_reg == S_WRITE_BURST) && bus.wr_burst_data_req && !beat_in_range;
  end

  // State and output registers
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      burst_req_reg  <= 1'b0;
      burst_len_reg  <= '0;
      burst_addr_reg <= '0;
      ack_reg        <= 1'b0;
      aclr_reg       <= 1'b0;
      finish_reg     <= 1'b0;
      overrun_reg    <= 1'b0;
      len_latch_reg  <= '0;
      write_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      beat_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      burst_req_reg  <= burst_req_next;
      burst_len_reg  <= burst_len_next;
      burst_addr_reg <= burst_addr_next;
      ack_reg        <= ack_next;
      aclr_reg       <= aclr_next;
      finish_reg     <= finish_next;
      overrun_reg    <= overrun_next;
      len_latch_reg  <= len_latch_next;
      write_cnt_reg  <= write_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      beat_cnt_reg   <= beat_cnt_next;
    end
  end

`ifdef FRAME_WR_TIMEOUT_EN
  // Starvation watchdog registers
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= timeout_next;
    end
  end
  assign write_timeout = timeout_reg;
`else
  assign write_timeout = 1'b0;
`endif

  assign bus.wr_burst_req  = burst_req_reg;
  assign bus.wr_burst_len  = burst_len_reg;
  assign bus.wr_burst_addr = burst_addr_reg;
  assign write_req_ack     = ack_reg;
  assign fifo_aclr         = aclr_reg;
  assign write_finish      = finish_reg;
  assign beat_overrun      = overrun_reg;

endmodule

// File: tb/tb_frame_fifo_write.sv
// Self-checking bench for frame_fifo_write: table-driven frames, randomized
// frames against a burst-list model, and hand sequences for starvation,
// abort/re-request, reset mid-burst and (with FRAME_WR_TIMEOUT_EN) timeout.
module tb_frame_fifo_write;

  localparam int ADDR_BITS   = 23;
  localparam int BURST_BITS  = 10;
  localparam int BURST_SIZE  = 16;
  localparam int WAIT_CYCLES = 200;
  localparam int MAX_CYC     = 4000;

  logic mem_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 mem_clk = ~mem_clk;

  frame_fifo_write_if #(.ADDR_BITS(ADDR_BITS), .BURST_BITS(BURST_BITS)) bus ();

  logic                 fifo_rden, write_req, write_req_ack, write_finish;
  logic                 fifo_aclr, beat_overrun, write_timeout;
  logic [ADDR_BITS-1:0] addr_tab [4];
  logic [1:0]           write_addr_index;
  logic [ADDR_BITS-1:0] write_len;
  logic [15:0]          rdusedw;

  frame_fifo_write #(
    .MEM_DATA_BITS (32),
    .ADDR_BITS     (ADDR_BITS),
    .BURST_BITS    (BURST_BITS),
    .BURST_SIZE    (BURST_SIZE),
    .WAIT_CYCLES   (WAIT_CYCLES)
`ifdef FRAME_WR_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (24'd500)
`endif
  ) dut (
    .rst              (rst),
    .mem_clk          (mem_clk),
    .bus              (bus.master),
    .fifo_rden        (fifo_rden),
    .write_req        (write_req),
    .write_req_ack    (write_req_ack),
    .write_finish     (write_finish),
    .write_addr_0     (addr_tab[0]),
    .write_addr_1     (addr_tab[1]),
    .write_addr_2     (addr_tab[2]),
    .write_addr_3     (addr_tab[3]),
    .write_addr_index (write_addr_index),
    .write_len        (write_len),
    .fifo_aclr        (fifo_aclr),
    .rdusedw          (rdusedw),
    .beat_overrun     (beat_overrun),
    .write_timeout    (write_timeout)
  );

  int checks = 0;
  int errors = 0;

  // Event counters sampled mid-cycle
  int rden_total = 0, ovr_total = 0, fin_total = 0, to_total = 0, aclr_total = 0;
  always @(negedge mem_clk) begin
    if (!rst) begin
      if (fifo_rden)     rden_total <= rden_total + 1;
      if (beat_overrun)  ovr_total  <= ovr_total + 1;
      if (write_finish)  fin_total  <= fin_total + 1;
      if (write_timeout) to_total   <= to_total + 1;
      if (fifo_aclr)     aclr_total <= aclr_total + 1;
    end
  end

  initial begin
    #(10 * 90000);
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  // Expected bursts of the current frame
  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    int                   len;
  } burst_t;
  burst_t exp_q[$];

  typedef struct {
    int                   idx;
    logic [ADDR_BITS-1:0] base;
    int                   len;
    int                   rdw;
    int                   extra;
    int                   exp_b;
    int                   exp_r;
    int                   exp_o;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mem_clk);
    #1;
  endtask

  // Frame split into bursts of BURST_SIZE with a shorter tail
  task automatic build_model(input logic [ADDR_BITS-1:0] base, input int len);
    int rem;
    int b;
    logic [ADDR_BITS-1:0] a;
    rem = len;
    a = base;
    exp_q.delete();
    while (rem > 0) begin
      b = (rem < BURST_SIZE) ? rem : BURST_SIZE;
      exp_q.push_back('{a, b});
      a = a + ADDR_BITS'(b);
      rem -= b;
    end
  endtask

  task automatic request_frame(input int idx, input int len, input int rdw);
    int n;
    write_addr_index = idx[1:0];
    write_len        = ADDR_BITS'(len);
    rdusedw          = rdw[15:0];
    write_req        = 1'b1;
    n = 0;
    while (!write_req_ack && n < 50) begin
      tick();
      n++;
    end
    check("req_ack", write_req_ack, 1);
    write_req = 1'b0;
  endtask

  // Controller side of one burst: len+extra data requests, then finish
  task automatic do_burst(input int extra);
    int blen;
    blen = int'(bus.wr_burst_len);
    if (blen > 64) blen = 64;
    bus.wr_burst_data_req = 1'b1;
    repeat (blen + extra) tick();
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b1;
    tick();
    bus.wr_burst_finish   = 1'b0;
  endtask

  // Serve bursts until write_finish, comparing each against the model
  task automatic service(input int extra, output int nb, output int cyc);
    bit done;
    burst_t e;
    nb = 0;
    cyc = 0;
    done = 0;
    while (!done && cyc < MAX_CYC && nb <= 40) begin
      if (write_finish) begin
        done = 1;
      end else if (bus.wr_burst_req) begin
        $display("burst addr=0x%0h len=%0d", bus.wr_burst_addr, bus.wr_burst_len);
        if (exp_q.size() == 0) begin
          check("burst_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("burst_addr", bus.wr_burst_addr, e.addr);
          check("burst_len", bus.wr_burst_len, e.len);
        end
        do_burst(extra);
        nb++;
      end else begin
        tick();
        cyc++;
      end
    end
    check("frame_done", done, 1);
    check("bursts_left", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int idx, input logic [ADDR_BITS-1:0] base, input int len,
                           input int rdw, input int extra,
                           input int exp_b, input int exp_r, input int exp_o);
    int r0, o0, f0, nb, cyc;
    addr_tab[idx] = base;
    build_model(base, len);
    r0 = rden_total;
    o0 = ovr_total;
    f0 = fin_total;
    request_frame(idx, len, rdw);
    service(extra, nb, cyc);
    tick();
    tick();
    check("burst_count", nb, exp_b);
    check("rden_count", rden_total - r0, exp_r);
    check("overrun_count", ovr_total - o0, exp_o);
    check("finish_count", fin_total - f0, 1);
    if (len == 0) check("zero_len_waited", cyc >= WAIT_CYCLES, 1);
    $display("frame idx=%0d base=0x%0h len=%0d bursts=%0d", idx, base, len, nb);
  endtask

  initial begin
    int n, nb, cyc, r0, f0, a0, t0, len, ext, bsts;
    bit seen;

    vecs[0] = '{2, 23'h001000, 40,  64, 0, 3, 40, 0};
    vecs[1] = '{0, 23'h000100, 16, 100, 2, 1, 16, 2};
    vecs[2] = '{1, 23'h000200,  0,   0, 0, 0,  0, 0};
    vecs[3] = '{3, 23'h7FFFF8, 20,  64, 0, 2, 20, 0};
    vecs[4] = '{1, 23'h000300,  5,   5, 0, 1,  5, 0};
    vecs[5] = '{0, 23'h000400, 33,  40, 1, 3, 33, 3};
    vecs[6] = '{2, 23'h000500, 17, 200, 0, 2, 17, 0};

    write_req             = 1'b0;
    write_addr_index      = '0;
    write_len             = '0;
    rdusedw               = '0;
    bus.wr_burst_data_req = 1'b0;
    bus.wr_burst_finish   = 1'b0;
    for (int i = 0; i < 4; i++) addr_tab[i] = '0;

    // Reset state
    repeat (3) tick();
    check("reset_burst_req", bus.wr_burst_req, 0);
    check("reset_burst_addr", bus.wr_burst_addr, 0);
    check("reset_burst_len", bus.wr_burst_len, 0);
    check("reset_misc", {write_req_ack, write_finish, fifo_aclr, beat_overrun, write_timeout, fifo_rden}, 0);
    rst = 1'b0;
    tick();

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].idx, vecs[i].base, vecs[i].len, vecs[i].rdw, vecs[i].extra,
                vecs[i].exp_b, vecs[i].exp_r, vecs[i].exp_o);
    end

    // Randomized frames against the model
    for (int i = 0; i < 5; i++) begin
      len  = int'($urandom_range(0, 70));
      ext  = int'($urandom_range(0, 1));
      bsts = (len + BURST_SIZE - 1) / BURST_SIZE;
      run_frame(int'($urandom_range(0, 3)), ADDR_BITS'($urandom), len, 64, ext,
                bsts, len, ext * bsts);
    end

    // FIFO starvation: no burst until enough words are present
    addr_tab[0] = 23'h002000;
    build_model(23'h002000, 40);
    r0 = rden_total;
    f0 = fin_total;
    request_frame(0, 40, 5);
    seen = 0;
    repeat (WAIT_CYCLES + 40) begin
      tick();
      if (bus.wr_burst_req) seen = 1;
    end
    check("starve_no_req", seen, 0);
    rdusedw = 16'd16;
    tick();
    check("starve_req_after_fill", bus.wr_burst_req, 1);
    rdusedw = 16'd64;
    service(0, nb, cyc);
    tick();
    tick();
    check("starve_rden", rden_total - r0, 40);
    check("starve_finish", fin_total - f0, 1);
    $display("frame starvation bursts=%0d", nb);

    // Re-request while stalled in the FIFO check after one burst
    addr_tab[0] = 23'h003000;
    f0 = fin_total;
    a0 = aclr_total;
    request_frame(0, 40, 16);
    n = 0;
    while (!bus.wr_burst_req && n < WAIT_CYCLES + 50) begin
      tick();
      n++;
    end
    check("rereq_first_req", bus.wr_burst_req, 1);
    check("rereq_first_addr", bus.wr_burst_addr, 23'h003000);
    rdusedw = 16'd0;
    do_burst(0);
    repeat (5) tick();
    check("rereq_stall", bus.wr_burst_req, 0);
    a0 = aclr_total;
    addr_tab[3] = 23'h005000;
    build_model(23'h005000, 20);
    request_frame(3, 20, 0);
    rdusedw = 16'd64;
    service(0, nb, cyc);
    tick();
    tick();
    check("rereq_aclr", (aclr_total - a0) > 0, 1);
    check("rereq_single_finish", fin_total - f0, 1);
    check("rereq_bursts", nb, 2);
    $display("frame re-request bursts=%0d", nb);

    // Reset in the middle of a burst
    addr_tab[1] = 23'h004000;
    request_frame(1, 40, 64);
    n = 0;
    while (!bus.wr_burst_req && n < WAIT_CYCLES + 50) begin
      tick();
      n++;
    end
    check("rst_mid_req", bus.wr_burst_req, 1);
    bus.wr_burst_data_req = 1'b1;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_burst_req", bus.wr_burst_req, 0);
    check("rst_mid_fifo_rden", fifo_rden, 0);
    check("rst_mid_addr", bus.wr_burst_addr, 0);
    check("rst_mid_len", bus.wr_burst_len, 0);
    check("rst_mid_misc", {write_req_ack, write_finish, fifo_aclr, beat_overrun, write_timeout}, 0);
    bus.wr_burst_data_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    run_frame(1, 23'h004000, 24, 64, 0, 2, 24, 0);

`ifdef FRAME_WR_TIMEOUT_EN
    // Watchdog abort with an empty FIFO
    t0 = to_total;
    f0 = fin_total;
    addr_tab[2] = 23'h006000;
    exp_q.delete();
    request_frame(2, 16, 0);
    service(0, nb, cyc);
    tick();
    tick();
    check("timeout_pulse", to_total - t0, 1);
    check("timeout_finish", fin_total - f0, 1);
    check("timeout_bursts", nb, 0);
    $display("frame timeout bursts=%0d", nb);
`else
    t0 = 0;
    check("no_timeout_pulses", to_total, t0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_fifo_write.md
Name: frame_fifo_write

Overview:
- Write-side frame mover, directly upstream of the frame read path.
- Drains the video-input write FIFO into external memory as bursts at a selectable base address (4 frame buffers); the read path later fetches those frames.
- Talks to the memory controller burst-write interface and reports per-frame completion.
- Last burst of a frame is shortened to the exact remaining length.

Parameters:
- MEM_DATA_BITS, 32, memory data width (bookkeeping only; no datapath inside).
- ADDR_BITS, 23, address, length and counter width.
- BURST_BITS, 10, wr_burst_len width.
- BURST_SIZE, 16, nominal words per burst; must be ≥1.
- WAIT_CYCLES, 200, settle cycles after fifo_aclr release.

Ports:
- rst  in  1  reset, asynchronous, active-high.
- mem_clk  in  1  clock.
- wr_burst_req  out  1  burst write request to controller.
- wr_burst_len  out  BURST_BITS  words in current burst.
- wr_burst_addr  out  ADDR_BITS  burst base address.
- wr_burst_data_req  in  1  controller wants one data word this cycle.
- wr_burst_finish  in  1  controller: burst complete (1-cycle pulse).
- fifo_rden  out  1  read strobe to write FIFO (combinational).
- write_req  in  1  async frame-write request; held until write_req_ack.
- write_req_ack  out  1  request acknowledge.
- write_finish  out  1  1-cycle pulse: frame written.
- write_addr_0..write_addr_3  in  ADDR_BITS each  frame buffer bases.
- write_addr_index  in  2  base select (async).
- write_len  in  ADDR_BITS  frame length in words (async).
- fifo_aclr  out  1  FIFO async clear.
- rdusedw  in  16  FIFO read-side used words.
- beat_overrun  out  1  1-cycle pulse: data_req beyond burst length.
- write_timeout  out  1  1-cycle pulse: frame aborted by watchdog.

Behaviour:
- Sync: write_req 3-flop (req_d2 used); write_len, write_addr_index 2-flop; all reset to 0.
- Reset values: all outputs 0, state S_IDLE, counters 0.
- States:
  - S_IDLE: ack=0; req_d2=1 -> S_ACK.
  - S_ACK: while req_d2=1: ack=1, fifo_aclr=1, latch addr[index_d1] into wr_burst_addr, latch len_d1, write_cnt=0. On req_d2=0: ack=0, aclr=0, wait_cnt=0 -> S_WAIT.
  - S_WAIT: count to WAIT_CYCLES -> S_CHECK_FIFO.
  - S_CHECK_FIFO:
    - req_d2=1 -> S_ACK (abort current frame).
    - else remaining = len_latch - write_cnt; remaining=0 -> S_END.
    - else blen = min(BURST_SIZE, remaining). If rdusedw (zero-extended) ≥ blen: wr_burst_len=blen, wr_burst_req=1, beat_cnt=0 -> S_WRITE_BURST.
  - S_WRITE_BURST:
    - wr_burst_req cleared on the first wr_burst_data_req.
    - fifo_rden = wr_burst_data_req & (beat_cnt < wr_burst_len); beat_cnt increments on each fifo_rden.
    - data_req with beat_cnt ≥ len: fifo_rden=0, beat_overrun pulses.
    - wr_burst_finish: write_cnt += len, addr += len -> S_WRITE_BURST_END.
    - A new request is not acted on mid-burst; it is held by the synchroniser.
  - S_WRITE_BURST_END: req_d2=1 -> S_ACK; write_cnt < len_latch -> S_CHECK_FIFO; else -> S_END.
  - S_END: write_finish=1 for one cycle -> S_IDLE.
- write_len=0: frame ends via S_CHECK_FIFO -> S_END with no burst.
- Arithmetic is modulo 2^ADDR_BITS; address wrap is not flagged.
- fifo_rden never asserts outside S_WRITE_BURST.
- Illegal state -> S_IDLE.

Optional Feature:
- Macro: FRAME_WR_TIMEOUT_EN.
- Defined:
  - 24-bit watchdog counts cycles in S_CHECK_FIFO with rdusedw < blen; any burst issue clears it.
  - Reaching parameter TIMEOUT_CYCLES (default 24'd1_000_000): write_timeout pulses -> S_END. write_finish still pulses.
- Undefined: no counter, write_timeout tied 0, S_CHECK_FIFO waits indefinitely.

Decomposition:
- Package frame_ddr3_pkg:
  - State encodings for this block and the read block.
  - Default burst/wait constants.
- Sub-module cdc_sync_bus (N-flop synchroniser, parameter WIDTH/STAGES) for req/len/index.
- Burst FSM stays in this module.

Test Plan:
- Normal frame: write_len=40, BURST_SIZE=16, index=2, addr_2=0x1000, rdusedw=64.
  - 3 bursts: len 16/16/8 at 0x1000/0x1010/0x1020.
  - 40 fifo_rden total; write_finish once.
- FIFO starvation: rdusedw=5, need 16 -> no wr_burst_req.
  - Raise to 16 -> burst issues the next cycle.
- Overrun: controller issues 18 data_req for a 16-word burst -> 16 fifo_rden, beat_overrun pulses twice.
- Re-request in S_CHECK_FIFO after 1 burst: write_cnt resets, new base latched, fifo_aclr re-asserted, old frame gets no write_finish.
- Reset mid-burst: all outputs 0 next edge. After release, new write_req runs a clean frame.
- write_len=0 -> write_finish after WAIT_CYCLES with zero bursts.
  - Timeout variant (FRAME_WR_TIMEOUT_EN): rdusedw held 0 -> write_timeout and write_finish pulse.
